// File: rtl/cpu5_fetch_unit_pkg.sv
// Shared CPU5 constants and fetch-unit types: core width, reset PC and fetch FSM encodings.
`ifndef CPU5_DEFINES_SVH
`define CPU5_DEFINES_SVH
`define CPU5_XLEN      32
`define CPU5_RESET_PC  32'h0000_0000
`define CPU5_IFU_RUN   1'b0
`define CPU5_IFU_HALT  1'b1
`endif

package cpu5_fetch_unit_pkg;

    typedef enum logic {
        IFU_RUN  = `CPU5_IFU_RUN,
        IFU_HALT = `CPU5_IFU_HALT
    } ifu_state_e;

    function automatic logic pc_aligned(input logic [1:0] pc_lsb);
        return pc_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/cpu5_fetch_outreg.sv
// Single-entry valid/ready holding register with flush; loads in the same cycle it drains.
// Latency 1 cycle; entry held stable while out_vld_o && !out_rdy_i.
module cpu5_fetch_outreg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_pc_i,
    input  logic [W-1:0] in_instr_i,
    input  logic         in_err_i,
    output logic         in_rdy_o,
    input  logic         out_rdy_i,
    output logic         out_vld_o,
    output logic [W-1:0] out_pc_o,
    output logic [W-1:0] out_instr_o,
    output logic         out_err_o
);

    logic         vld_q;
    logic [W-1:0] pc_q;
    logic [W-1:0] instr_q;
    logic         err_q;

    assign in_rdy_o = !vld_q || out_rdy_i;

    // A flush overwrites the slot regardless of whether decode is draining it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_q   <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else if (flush_i || (in_vld_i && in_rdy_o)) begin
            vld_q   <= in_vld_i;
            pc_q    <= in_pc_i;
            instr_q <= in_instr_i;
            err_q   <= in_err_i;
        end else if (out_rdy_i) begin
            vld_q   <= 1'b0;
        end
    end

    assign out_vld_o   = vld_q;
    assign out_pc_o    = pc_q;
    assign out_instr_o = instr_q;
    assign out_err_o   = err_q;

endmodule

// File: rtl/cpu5_fetch_unit.sv
// Instruction fetch: owns the fetch PC, reads the combinational icache, registers {pc, instr} toward decode.
// Latency 1 cycle from address to out_valid; stalls on !out_ready, halts after a misaligned redirect.
module cpu5_fetch_unit
    import cpu5_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = `CPU5_XLEN,
    parameter int              IADDR_W  = 8,
    parameter logic [XLEN-1:0] RESET_PC = `CPU5_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IADDR_W-1:0] icache_a,
    input  logic [XLEN-1:0]    icache_q,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_instr,
    output logic               out_err
);

    logic [XLEN-1:0] fpc_q, fpc_d;
    ifu_state_e      state_q, state_d;
    logic            accept;
    logic            redir_ok;
    logic            ent_vld;
    logic [XLEN-1:0] ent_pc;
    logic [XLEN-1:0] ent_instr;
    logic            ent_err;

    assign redir_ok = pc_aligned(redirect_pc[1:0]);

    // Redirect target drives the cache directly so the new stream starts without a bubble.
    assign icache_a = redirect_valid ? redirect_pc[IADDR_W+1:2] : fpc_q[IADDR_W+1:2];

    always_comb begin
        fpc_d     = fpc_q;
        state_d   = state_q;
        ent_vld   = 1'b0;
        ent_pc    = fpc_q;
        ent_instr = icache_q;
        ent_err   = 1'b0;
        if (redirect_valid) begin
            ent_vld   = 1'b1;
            ent_pc    = redirect_pc;
            ent_instr = redir_ok ? icache_q : '0;
            ent_err   = !redir_ok;
            fpc_d     = redir_ok ? redirect_pc + XLEN'(4) : redirect_pc;
            state_d   = redir_ok ? IFU_RUN : IFU_HALT;
        end else if (state_q == IFU_RUN) begin
            ent_vld = 1'b1;
            if (accept) begin
                fpc_d = fpc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q   <= RESET_PC;
            state_q <= IFU_RUN;
        end else begin
            fpc_q   <= fpc_d;
            state_q <= state_d;
        end
    end

    cpu5_fetch_outreg #(.W(XLEN)) u_outreg (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (redirect_valid),
        .in_vld_i    (ent_vld),
        .in_pc_i     (ent_pc),
        .in_instr_i  (ent_instr),
        .in_err_i    (ent_err),
        .in_rdy_o    (accept),
        .out_rdy_i   (out_ready),
        .out_vld_o   (out_valid),
        .out_pc_o    (out_pc),
        .out_instr_o (out_instr),
        .out_err_o   (out_err)
    );

endmodule

// File: tb/tb_cpu5_fetch_unit.sv
// Directed plus randomized bench for cpu5_fetch_unit against a behavioural fetch-stream model.
module tb_cpu5_fetch_unit;

    logic        clk;
    logic        reset;
    logic [7:0]  icache_a;
    logic [31:0] icache_q;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_err;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model: next PC to fetch, halted flag, and the entry decode should see
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_vld;
    logic [31:0] m_opc;
    logic [31:0] m_instr;
    logic        m_err;

    cpu5_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .icache_a       (icache_a),
        .icache_q       (icache_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_err        (out_err)
    );

    assign icache_q = mem[icache_a];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] byte_pc);
        return mem[(byte_pc / 4) % 256];
    endfunction

    task automatic model_edge(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        if (rst) begin
            m_pc = 32'h0; m_halt = 1'b0;
            m_vld = 1'b0; m_opc = 32'h0; m_instr = 32'h0; m_err = 1'b0;
        end else if (rv) begin
            m_vld = 1'b1;
            m_opc = rpc;
            if (rpc % 4 == 0) begin
                m_instr = word_at(rpc); m_err = 1'b0; m_pc = rpc + 32'd4; m_halt = 1'b0;
            end else begin
                m_instr = 32'h0; m_err = 1'b1; m_pc = rpc; m_halt = 1'b1;
            end
        end else if (!m_halt && (!m_vld || rdy)) begin
            m_vld = 1'b1; m_opc = m_pc; m_instr = word_at(m_pc); m_err = 1'b0;
            m_pc = m_pc + 32'd4;
        end else if (m_halt && rdy) begin
            m_vld = 1'b0;
        end
    endtask

    // One clock: drive inputs, check the cache address, clock, then check the output entry.
    task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] a_exp;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        if (!rst) begin
            a_exp = ((rv ? rpc : m_pc) / 4) % 256;
            check("icache_a", {24'h0, icache_a}, a_exp);
        end
        @(posedge clk);
        model_edge(rst, rv, rpc, rdy);
        @(negedge clk);
        check("out_valid", {31'h0, out_valid}, {31'h0, m_vld});
        if (m_vld || rst) begin
            check("out_pc",    out_pc,    m_opc);
            check("out_instr", out_instr, m_instr);
            check("out_err",   {31'h0, out_err}, {31'h0, m_err});
        end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        m_pc = 32'h0; m_halt = 1'b0; m_vld = 1'b0; m_opc = 32'h0; m_instr = 32'h0; m_err = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;

        // reset and streaming
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        cycle(0, 0, 0, 1);
        check("t1_pc0", out_pc, 32'h0);
        check("t1_ins0", out_instr, 32'h1000);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("t1_pc8", out_pc, 32'h8);
        check("t1_ins8", out_instr, 32'h1002);

        // backpressure
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            check("t2_hold_pc", out_pc, 32'h8);
            check("t2_hold_ins", out_instr, 32'h1002);
            check("t2_addr", {24'h0, icache_a}, 32'd3);
        end
        cycle(0, 0, 0, 1);
        check("t2_next_pc", out_pc, 32'd12);

        // redirect while decode is accepting
        cycle(0, 1, 32'h40, 1);
        check("t3_pc", out_pc, 32'h40);
        check("t3_ins", out_instr, 32'h1010);
        cycle(0, 0, 0, 1);
        check("t3_pc2", out_pc, 32'h44);

        // misaligned redirect, halt, then resume
        cycle(0, 1, 32'h42, 0);
        check("t4_err", {31'h0, out_err}, 32'h1);
        check("t4_ins", out_instr, 32'h0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
        check("t4_idle", {31'h0, out_valid}, 32'h0);
        cycle(0, 1, 32'h80, 1);
        check("t4_resume_pc", out_pc, 32'h80);
        check("t4_resume_ins", out_instr, 32'h1020);

        // address wrap
        cycle(0, 1, 32'h3F8, 1);
        cycle(0, 0, 0, 1);
        check("t5_pc_3fc", out_pc, 32'h3FC);
        cycle(0, 0, 0, 1);
        check("t5_pc_400", out_pc, 32'h400);
        check("t5_ins_400", out_instr, 32'h1000);

        // reset in HALT with a pending fault, and reset beating redirect
        cycle(0, 1, 32'h42, 0);
        cycle(1, 0, 0, 0);
        check("t6_rst_vld", {31'h0, out_valid}, 32'h0);
        check("t6_rst_pc", out_pc, 32'h0);
        cycle(1, 1, 32'h80, 1);
        check("t6_rst_wins", out_pc, 32'h0);
        cycle(0, 0, 0, 1);
        check("t6_restart_pc", out_pc, 32'h0);

        // randomized traffic
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 1500; i++) begin
            logic        r_rst, r_rv, r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 59) == 0);
            r_rv  = ($urandom_range(0, 7) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_pc  = $urandom;
            if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
            cycle(r_rst, r_rv, r_pc, r_rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
